br_credit_pool_arb: RTL and testbench

- Shares one credit pool among NumRequesters requesters; the pool is a bounded up/down counter.
- Each requester asks for a multi-credit amount. A round-robin arbiter grants at most one request per cycle, and only when the pool holds enough credits.
- One release port returns credits to the pool.
- Sits in front of shared buffers or link credits, as the sequencing/allocation layer over a counter resource.

---
 rtl/br_credit_pool_arb.sv | 173 +++++++++++++++++
 tb/tb_br_credit_pool_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/br_credit_pool_arb.sv
// Credit pool shared by several requesters. A round-robin arbiter grants at most one
// multi-credit request per cycle, and only when the registered pool can fund it.

module br_credit_pool_arb_chk #(
    parameter int NumRequesters = 4,
    parameter int MaxCredits    = 16,
    parameter int CountWidth    = 5,
    parameter int ChangeWidth   = 3
) (
    input logic                               clk,
    input logic                               rst,
    input logic                               reinit,
    input logic [NumRequesters-1:0]           req_valid,
    input logic [NumRequesters*ChangeWidth-1:0] req_amount,
    input logic [NumRequesters-1:0]           grant,
    input logic [CountWidth-1:0]              available,
    input logic [CountWidth:0]                pool_sum
);
    logic [7:0] bypass_cnt_r [NumRequesters];

    // Counts grants handed to others while each requester waits; round-robin bounds this.
    always_ff @(posedge clk or posedge rst) begin
        for (int k = 0; k < NumRequesters; k++) begin
            if (rst) begin
                bypass_cnt_r[k] <= 8'd0;
            end else if (reinit || !req_valid[k] || grant[k]) begin
                bypass_cnt_r[k] <= 8'd0;
            end else if (grant != {NumRequesters{1'b0}}) begin
                bypass_cnt_r[k] <= bypass_cnt_r[k] + 8'd1;
            end else begin
                bypass_cnt_r[k] <= bypass_cnt_r[k];
            end
        end
    end

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_avail_bound: assert property (@(posedge clk) disable iff (rst)
        available <= CountWidth'(MaxCredits));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !reinit |-> pool_sum <= (CountWidth+1)'(MaxCredits));

    for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_req
        a_req_stable: assert property (@(posedge clk) disable iff (rst)
            (req_valid[gi] && !grant[gi]) |=>
            (req_valid[gi] && $stable(req_amount[gi*ChangeWidth +: ChangeWidth])));
        a_no_starve: assert property (@(posedge clk) disable iff (rst)
            bypass_cnt_r[gi] <= 8'(NumRequesters - 1));
    end
endmodule

module br_credit_pool_arb #(
    parameter int NumRequesters = 4,
    parameter int MaxCredits    = 16,
    parameter int MaxChange     = 4,
    parameter int ResetCredits  = MaxCredits,
    localparam int CountWidth   = $clog2(MaxCredits + 1),
    localparam int ChangeWidth  = $clog2(MaxChange + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 reinit,
    input  logic [CountWidth-1:0]                initial_credits,
    input  logic [NumRequesters-1:0]             req_valid,
    input  logic [NumRequesters*ChangeWidth-1:0] req_amount,
    output logic [NumRequesters-1:0]             grant,
    output logic [ChangeWidth-1:0]               grant_amount,
    input  logic                                 release_valid,
    input  logic [ChangeWidth-1:0]               release_amount,
    output logic [CountWidth-1:0]                available,
    output logic [CountWidth-1:0]                available_next
);
    localparam int PtrWidth = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
    localparam int SumWidth = CountWidth + 1;

    logic [CountWidth-1:0]  available_r;
    logic [PtrWidth-1:0]    ptr_r;
    logic [PtrWidth-1:0]    winner_s;
    logic [PtrWidth-1:0]    ptr_next_s;
    logic                   found_s;
    logic                   do_grant_s;
    logic [ChangeWidth-1:0] winner_amount_s;
    logic [SumWidth-1:0]    pool_sum_s;

    function automatic logic [PtrWidth-1:0] rr_index(input logic [PtrWidth-1:0] base,
                                                     input int offset);
        int pos_v;
        pos_v = int'(base) + offset;
        if (pos_v >= NumRequesters) begin
            pos_v = pos_v - NumRequesters;
        end else begin
            pos_v = pos_v;
        end
        return PtrWidth'(pos_v);
    endfunction

    // Round-robin winner search starting at ptr; the winner alone may be granted (no bypass).
    always_comb begin
        found_s  = 1'b0;
        winner_s = {PtrWidth{1'b0}};
        for (int k = 0; k < NumRequesters; k++) begin
            if (!found_s && req_valid[rr_index(ptr_r, k)]) begin
                found_s  = 1'b1;
                winner_s = rr_index(ptr_r, k);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant decision and pool arithmetic; releases only land after the grant check.
    always_comb begin
        winner_amount_s = req_amount[winner_s*ChangeWidth +: ChangeWidth];
        do_grant_s      = found_s && !reinit && !rst &&
                          (CountWidth'(winner_amount_s) <= available_r);
        grant           = {NumRequesters{1'b0}};
        grant_amount    = {ChangeWidth{1'b0}};
        if (do_grant_s) begin
            grant        = NumRequesters'(1'b1) << winner_s;
            grant_amount = winner_amount_s;
        end else begin
            grant        = {NumRequesters{1'b0}};
            grant_amount = {ChangeWidth{1'b0}};
        end
        pool_sum_s = SumWidth'(available_r) - SumWidth'(grant_amount);
        if (release_valid) begin
            pool_sum_s = pool_sum_s + SumWidth'(release_amount);
        end else begin
            pool_sum_s = pool_sum_s;
        end
        if (reinit) begin
            available_next = initial_credits;
        end else begin
            available_next = pool_sum_s[CountWidth-1:0];
        end
        if (winner_s == PtrWidth'(NumRequesters - 1)) begin
            ptr_next_s = {PtrWidth{1'b0}};
        end else begin
            ptr_next_s = winner_s + PtrWidth'(1);
        end
    end

    // Pool and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            available_r <= CountWidth'(ResetCredits);
            ptr_r       <= {PtrWidth{1'b0}};
        end else if (reinit) begin
            available_r <= initial_credits;
            ptr_r       <= {PtrWidth{1'b0}};
        end else begin
            available_r <= available_next;
            ptr_r       <= do_grant_s ? ptr_next_s : ptr_r;
        end
    end

    assign available = available_r;

    br_credit_pool_arb_chk #(
        .NumRequesters(NumRequesters),
        .MaxCredits   (MaxCredits),
        .CountWidth   (CountWidth),
        .ChangeWidth  (ChangeWidth)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .reinit    (reinit),
        .req_valid (req_valid),
        .req_amount(req_amount),
        .grant     (grant),
        .available (available_r),
        .pool_sum  (pool_sum_s)
    );
endmodule

// File: tb/tb_br_credit_pool_arb.sv
// Directed bench for br_credit_pool_arb: an integer-level pool/round-robin model checked
// every cycle, plus hand-computed expectations for each scenario.

module tb_br_credit_pool_arb;
    localparam int N   = 4;
    localparam int MC  = 16;
    localparam int MCH = 4;
    localparam int CW  = 5;
    localparam int HW  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reinit = 1'b0;
    logic [CW-1:0] initial_credits = 5'd0;
    logic [N-1:0]  req_valid = 4'd0;
    logic [N*HW-1:0] req_amount = 12'd0;
    logic [N-1:0]  grant;
    logic [HW-1:0] grant_amount;
    logic          release_valid = 1'b0;
    logic [HW-1:0] release_amount = 3'd0;
    logic [CW-1:0] available;
    logic [CW-1:0] available_next;

    int checks = 0;
    int errors = 0;
    int avail_m = MC;
    int ptr_m = 0;

    br_credit_pool_arb #(
        .NumRequesters(N), .MaxCredits(MC), .MaxChange(MCH), .ResetCredits(MC)
    ) dut (
        .clk(clk), .rst(rst), .reinit(reinit), .initial_credits(initial_credits),
        .req_valid(req_valid), .req_amount(req_amount), .grant(grant),
        .grant_amount(grant_amount), .release_valid(release_valid),
        .release_amount(release_amount), .available(available),
        .available_next(available_next)
    );

    always #5 clk = ~clk;

    function automatic logic [N*HW-1:0] amts(input int a0, input int a1, input int a2, input int a3);
        return {HW'(a3), HW'(a2), HW'(a1), HW'(a0)};
    endfunction

    function automatic int amount_of(input int i);
        return int'(req_amount[i*HW +: HW]);
    endfunction

    // Pool rules at integer level: oldest-in-rotation requester wins, funded only by the pool.
    function automatic void model_eval(output int g, output int ga, output int an, output int w);
        g = 0; ga = 0; w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && req_valid[(ptr_m + k) % N]) w = (ptr_m + k) % N;
        end
        if (w >= 0 && !reinit && amount_of(w) <= avail_m) begin
            g  = 1 << w;
            ga = amount_of(w);
        end
        if (reinit) an = int'(initial_credits);
        else an = avail_m - ga + (release_valid ? int'(release_amount) : 0);
    endfunction

    // Model state advance.
    always @(posedge clk or posedge rst) begin : model_upd
        int g, ga, an, w;
        if (rst) begin
            avail_m <= MC;
            ptr_m   <= 0;
        end else begin
            model_eval(g, ga, an, w);
            avail_m <= an;
            if (reinit) ptr_m <= 0;
            else if (g != 0) ptr_m <= (w + 1) % N;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick_check();
        int g, ga, an, w;
        @(negedge clk);
        if (!rst) begin
            model_eval(g, ga, an, w);
            chk("model_grant", int'(grant), g);
            chk("model_grant_amount", int'(grant_amount), ga);
            chk("model_available", int'(available), avail_m);
            chk("model_available_next", int'(available_next), an);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reinit(input int v);
        reinit = 1'b1;
        initial_credits = CW'(v);
        tick_check();
        chk("reinit_grant_zero", int'(grant), 0);
        adv();
        reinit = 1'b0;
    endtask

    initial begin
        logic [N-1:0] v;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick_check();
        chk("reset_available", int'(available), 16);
        chk("reset_grant", int'(grant), 0);
        adv();

        // Round robin with unit requests, winding each requester down after its last grant.
        req_amount = amts(1, 1, 1, 1);
        for (int c = 0; c < 8; c++) begin
            v = 4'hF;
            if (c >= 5) v = v << (c - 4);
            req_valid = v;
            tick_check();
            chk("rr_grant", int'(grant), 1 << (c % 4));
            chk("rr_available", int'(available), 16 - c);
            adv();
        end
        req_valid = 4'b0000;

        // Head-of-line hold: req0 wants 4 with only 3 available.
        do_reinit(3);
        req_valid = 4'b0011; req_amount = amts(4, 1, 0, 0);
        repeat (2) begin
            tick_check();
            chk("hol_hold", int'(grant), 0);
            adv();
        end
        release_valid = 1'b1; release_amount = 3'd1;
        tick_check();
        chk("release_no_fund", int'(grant), 0);
        chk("release_avail_next", int'(available_next), 4);
        adv();
        release_valid = 1'b0;
        tick_check();
        chk("hol_grant", int'(grant), 1);
        chk("hol_grant_amount", int'(grant_amount), 4);
        chk("hol_avail_next", int'(available_next), 0);
        adv();
        req_amount = amts(0, 1, 0, 0);
        tick_check();
        chk("ptr_at_1_holds", int'(grant), 0);
        adv();
        release_valid = 1'b1; release_amount = 3'd2;
        tick_check();
        adv();
        release_valid = 1'b0;
        tick_check();
        chk("req1_grant", int'(grant), 2);
        chk("req1_avail_next", int'(available_next), 1);
        adv();
        req_valid = 4'b0001;
        tick_check();
        chk("req0_zero_grant", int'(grant), 1);
        adv();
        req_valid = 4'b0000;

        // Grant and release in the same cycle.
        do_reinit(3);
        req_valid = 4'b0001; req_amount = amts(2, 0, 0, 0);
        release_valid = 1'b1; release_amount = 3'd4;
        tick_check();
        chk("simul_grant", int'(grant), 1);
        chk("simul_avail_next", int'(available_next), 5);
        adv();
        req_valid = 4'b0000; release_valid = 1'b0;
        tick_check();
        chk("simul_available", int'(available), 5);
        adv();

        // reinit with pending requests and a release; ptr is 1 beforehand.
        reinit = 1'b1; initial_credits = 5'd7;
        req_valid = 4'b1001; req_amount = amts(1, 0, 0, 1);
        release_valid = 1'b1; release_amount = 3'd1;
        tick_check();
        chk("reinit_grant", int'(grant), 0);
        chk("reinit_grant_amount", int'(grant_amount), 0);
        chk("reinit_avail_next", int'(available_next), 7);
        adv();
        reinit = 1'b0; release_valid = 1'b0;
        tick_check();
        chk("post_reinit_grant", int'(grant), 1);
        chk("post_reinit_available", int'(available), 7);
        adv();
        req_valid = 4'b1000;
        tick_check();
        chk("post_reinit_req3", int'(grant), 8);
        adv();
        req_valid = 4'b0000;

        // Zero-amount request on an empty pool.
        do_reinit(0);
        req_valid = 4'b0100; req_amount = amts(0, 0, 0, 0);
        tick_check();
        chk("zero_grant", int'(grant), 4);
        chk("zero_grant_amount", int'(grant_amount), 0);
        chk("zero_avail_next", int'(available_next), 0);
        adv();
        req_valid = 4'b1001;
        tick_check();
        chk("zero_available", int'(available), 0);
        chk("zero_ptr_at_3", int'(grant), 8);
        adv();
        req_valid = 4'b0001;
        tick_check();
        chk("zero_req0", int'(grant), 1);
        adv();
        req_valid = 4'b0000;

        // Asynchronous reset in the middle of a burst.
        do_reinit(16);
        req_valid = 4'b1111; req_amount = amts(2, 2, 2, 2);
        repeat (2) begin
            tick_check();
            adv();
        end
        rst = 1'b1;
        #1;
        chk("async_rst_grant", int'(grant), 0);
        chk("async_rst_grant_amount", int'(grant_amount), 0);
        adv();
        adv();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            v = 4'hF;
            v = v << c;
            req_valid = v;
            tick_check();
            chk("post_rst_grant", int'(grant), 1 << c);
            chk("post_rst_available", int'(available), 16 - 2 * c);
            adv();
        end
        req_valid = 4'b0000;
        tick_check();
        chk("idle_avail_next", int'(available_next), 8);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
